// File: rtl/hilo_pipe_if.sv
// E-stage request/response bundle for the pipelined HI/LO unit.
// master drives the E-stage controls and operands; slave is the HI/LO unit.
interface hilo_pipe_if #(
    parameter int unsigned DW = 32
);
    logic          stallE;
    logic          flushE;
    logic          flushM;
    logic [1:0]    weE;
    logic [1:0]    modeE;
    logic [DW-1:0] hi_i;
    logic [DW-1:0] lo_i;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;
    logic [DW-1:0] hi_arch;
    logic [DW-1:0] lo_arch;
    logic          busy;

    modport master (
        output stallE, flushE, flushM, weE, modeE, hi_i, lo_i,
        input  hi_o, lo_o, hi_arch, lo_arch, busy
    );

    modport slave (
        input  stallE, flushE, flushM, weE, modeE, hi_i, lo_i,
        output hi_o, lo_o, hi_arch, lo_arch, busy
    );
endinterface

// File: rtl/hilo_pipe.sv
// Pipelined HI/LO register unit: E-stage capture, M/W pending slots, W commit,
// youngest-first forwarding to E, and MADD/MSUB-style accumulate.
module hilo_pipe #(
    parameter int unsigned DW = 32
) (
    input  logic        clk,
    input  logic        rst,
    hilo_pipe_if.slave  bus
);
    localparam int unsigned AW = 2 * DW;

    typedef struct packed {
        logic          valid;
        logic [1:0]    we;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
    } slot_t;

    slot_t         m_q;
    slot_t         w_q;
    slot_t         m_d;
    logic [DW-1:0] hi_arch_q;
    logic [DW-1:0] lo_arch_q;
    logic [DW-1:0] fwd_hi;
    logic [DW-1:0] fwd_lo;
    logic [AW-1:0] acc_base;
    logic [AW-1:0] acc_opnd;
    logic [AW-1:0] acc_res;
    logic          req;

    // Per-half forwarding: M beats W beats architectural state
    always_comb begin
        fwd_hi = hi_arch_q;
        fwd_lo = lo_arch_q;
        if (w_q.valid && w_q.we[1]) fwd_hi = w_q.hi;
        if (w_q.valid && w_q.we[0]) fwd_lo = w_q.lo;
        if (m_q.valid && m_q.we[1]) fwd_hi = m_q.hi;
        if (m_q.valid && m_q.we[0]) fwd_lo = m_q.lo;
    end

    // Accumulate on the forwarded view so back-to-back MADD/MSUB chain freely
    always_comb begin
        acc_base = {fwd_hi, fwd_lo};
        acc_opnd = {bus.hi_i, bus.lo_i};
        acc_res  = (bus.modeE == 2'b10) ? (acc_base - acc_opnd) : (acc_base + acc_opnd);
    end

    // Resolve the E request into the slot image captured by M
    always_comb begin
        m_d = '0;
        req = ~bus.stallE & ~bus.flushE & (bus.modeE != 2'b11) &
              ((bus.modeE != 2'b00) | (bus.weE != 2'b00));
        if (req) begin
            m_d.valid = 1'b1;
            if (bus.modeE == 2'b00) begin
                m_d.we = bus.weE;
                m_d.hi = bus.hi_i;
                m_d.lo = bus.lo_i;
            end else begin
                m_d.we = 2'b11;
                m_d.hi = acc_res[AW-1:DW];
                m_d.lo = acc_res[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            w_q       <= '0;
            hi_arch_q <= '0;
            lo_arch_q <= '0;
        end else begin
            m_q <= m_d;
            w_q <= bus.flushM ? slot_t'('0) : m_q;
            if (w_q.valid && w_q.we[1]) hi_arch_q <= w_q.hi;
            if (w_q.valid && w_q.we[0]) lo_arch_q <= w_q.lo;
        end
    end

    assign bus.hi_o    = fwd_hi;
    assign bus.lo_o    = fwd_lo;
    assign bus.hi_arch = hi_arch_q;
    assign bus.lo_arch = lo_arch_q;
    assign bus.busy    = m_q.valid | w_q.valid;
endmodule

// File: tb/tb_hilo_pipe.sv
// Bench for hilo_pipe: directed vector table, async reset sequences and
// randomized traffic checked against a write-queue model of the HI/LO unit.
module tb_hilo_pipe;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hilo_pipe_if #(.DW(DW)) bus ();

    hilo_pipe #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: list of in-flight writes (index 0 = youngest) plus architectural HI/LO
    typedef struct {
        bit          v;
        bit [1:0]    we;
        bit [DW-1:0] hi;
        bit [DW-1:0] lo;
    } wr_t;

    wr_t         pend [2];
    bit [DW-1:0] ahi;
    bit [DW-1:0] alo;

    typedef struct {
        bit          st;
        bit          fe;
        bit          fm;
        bit [1:0]    we;
        bit [1:0]    mode;
        bit [DW-1:0] hi;
        bit [DW-1:0] lo;
        bit [DW-1:0] e_hio;
        bit [DW-1:0] e_loo;
        bit [DW-1:0] e_ha;
        bit [DW-1:0] e_la;
        bit          e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) pend[i] = '{v: 1'b0, we: 2'b00, hi: '0, lo: '0};
        ahi = '0;
        alo = '0;
    endfunction

    function automatic bit [DW-1:0] view(input bit half_hi);
        for (int i = 0; i < 2; i++)
            if (pend[i].v && pend[i].we[half_hi ? 1 : 0]) return half_hi ? pend[i].hi : pend[i].lo;
        return half_hi ? ahi : alo;
    endfunction

    function automatic bit model_busy();
        return pend[0].v || pend[1].v;
    endfunction

    function automatic void model_step(input bit st, input bit fe, input bit fm,
                                       input bit [1:0] we, input bit [1:0] mode,
                                       input bit [DW-1:0] hi, input bit [DW-1:0] lo);
        wr_t         nw;
        bit [2*DW-1:0] sum;
        nw = '{v: 1'b0, we: 2'b00, hi: '0, lo: '0};
        if (!st && !fe && mode != 2'b11 && !(mode == 2'b00 && we == 2'b00)) begin
            nw.v = 1'b1;
            if (mode == 2'b00) begin
                nw.we = we;
                nw.hi = hi;
                nw.lo = lo;
            end else begin
                if (mode == 2'b01) sum = {view(1'b1), view(1'b0)} + {hi, lo};
                else               sum = {view(1'b1), view(1'b0)} - {hi, lo};
                nw.we = 2'b11;
                nw.hi = sum[2*DW-1:DW];
                nw.lo = sum[DW-1:0];
            end
        end
        if (pend[1].v && pend[1].we[1]) ahi = pend[1].hi;
        if (pend[1].v && pend[1].we[0]) alo = pend[1].lo;
        pend[1] = fm ? '{v: 1'b0, we: 2'b00, hi: '0, lo: '0} : pend[0];
        pend[0] = nw;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".hi_o"},    bus.hi_o,    view(1'b1));
        chk({tag, ".lo_o"},    bus.lo_o,    view(1'b0));
        chk({tag, ".hi_arch"}, bus.hi_arch, ahi);
        chk({tag, ".lo_arch"}, bus.lo_arch, alo);
        chk({tag, ".busy"},    DW'(bus.busy), DW'(model_busy()));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".hi_o"},    bus.hi_o,    '0);
        chk({tag, ".lo_o"},    bus.lo_o,    '0);
        chk({tag, ".hi_arch"}, bus.hi_arch, '0);
        chk({tag, ".lo_arch"}, bus.lo_arch, '0);
        chk({tag, ".busy"},    DW'(bus.busy), '0);
    endtask

    // One clock: drive E inputs, advance model at the edge, compare 1ns later
    task automatic cycle(input bit st, input bit fe, input bit fm,
                         input bit [1:0] we, input bit [1:0] mode,
                         input bit [DW-1:0] hi, input bit [DW-1:0] lo);
        bus.stallE = st;
        bus.flushE = fe;
        bus.flushM = fm;
        bus.weE    = we;
        bus.modeE  = mode;
        bus.hi_i   = hi;
        bus.lo_i   = lo;
        @(posedge clk);
        model_step(st, fe, fm, we, mode, hi, lo);
        #1;
        chk_model("model");
    endtask

    // Reset asserted mid-cycle must clear everything before the next edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 chk_zero({tag, ".during"});
        @(negedge clk);
        rst = 1'b0;
        #1 chk_zero({tag, ".after"});
    endtask

    function automatic vec_t mk(input bit st, input bit fe, input bit fm,
                                input bit [1:0] we, input bit [1:0] mode,
                                input bit [DW-1:0] hi, input bit [DW-1:0] lo,
                                input bit [DW-1:0] ehio, input bit [DW-1:0] eloo,
                                input bit [DW-1:0] eha, input bit [DW-1:0] ela, input bit eb);
        return '{st: st, fe: fe, fm: fm, we: we, mode: mode, hi: hi, lo: lo,
                 e_hio: ehio, e_loo: eloo, e_ha: eha, e_la: ela, e_busy: eb};
    endfunction

    initial begin
        bit [1:0]    rmode;
        bit [1:0]    rwe;
        bit [DW-1:0] rhi;
        bit [DW-1:0] rlo;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.stallE = 1'b0;
        bus.flushE = 1'b0;
        bus.flushM = 1'b0;
        bus.weE    = 2'b00;
        bus.modeE  = 2'b00;
        bus.hi_i   = '0;
        bus.lo_i   = '0;
        model_reset();

        // Directed table: inputs for one cycle, expected outputs after that edge
        //            st fe fm  we     mode   hi            lo            hi_o          lo_o          hi_arch       lo_arch       busy
        tbl.push_back(mk(0, 0, 0, 2'b10, 2'b00, 32'hAAAA_0001, 32'h5,        32'hAAAA_0001, 32'h0,        32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h1234,      32'h5678,     32'hAAAA_0001, 32'h0,        32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'hAAAA_0001, 32'h0,        32'hAAAA_0001, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 2'b11, 2'b00, 32'h1,         32'hFFFF_FFFF, 32'h1,        32'hFFFF_FFFF, 32'hAAAA_0001, 32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b01, 32'h0,         32'h1,        32'h2,         32'h0,        32'hAAAA_0001, 32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'h2,         32'h0,        32'h1,        32'hFFFF_FFFF, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'h2,         32'h0,        32'h2,        32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 2'b11, 2'b00, 32'h0,         32'h0,        32'h0,         32'h0,        32'h2,        32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'h0,         32'h0,        32'h2,        32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'h0,         32'h0,        32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 32'h0,         32'h1,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       32'h0,        1));
        tbl.push_back(mk(0, 1, 0, 2'b10, 2'b00, 32'h7,         32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, 0, 0, 2'b10, 2'b00, 32'h9,         32'h0,        32'h9,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(0, 0, 1, 2'b00, 2'b00, 32'h0,         32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 0, 2'b11, 2'b00, 32'h3,     32'h4,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(0, 0, 0, 2'b11, 2'b00, 32'h3,         32'h4,        32'h3,         32'h4,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'h3,         32'h4,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 32'h0,         32'h0,        32'h3,         32'h4,        32'h3,        32'h4,        0));
        tbl.push_back(mk(0, 0, 0, 2'b11, 2'b11, 32'h5,         32'h6,        32'h3,         32'h4,        32'h3,        32'h4,        0));
        tbl.push_back(mk(1, 1, 0, 2'b11, 2'b00, 32'h5,         32'h6,        32'h3,         32'h4,        32'h3,        32'h4,        0));
        tbl.push_back(mk(0, 0, 0, 2'b01, 2'b00, 32'h5,         32'h6,        32'h3,         32'h6,        32'h3,        32'h4,        1));

        // Reset held from time zero, released away from a clock edge
        #12 chk_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        #1 chk_zero("rst_release");

        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].fe, tbl[i].fm, tbl[i].we, tbl[i].mode, tbl[i].hi, tbl[i].lo);
            chk($sformatf("vec%0d.hi_o", i),    bus.hi_o,    tbl[i].e_hio);
            chk($sformatf("vec%0d.lo_o", i),    bus.lo_o,    tbl[i].e_loo);
            chk($sformatf("vec%0d.hi_arch", i), bus.hi_arch, tbl[i].e_ha);
            chk($sformatf("vec%0d.lo_arch", i), bus.lo_arch, tbl[i].e_la);
            chk($sformatf("vec%0d.busy", i),    DW'(bus.busy), DW'(tbl[i].e_busy));
        end

        // Reset with both slots holding writes and nonzero architectural state
        cycle(0, 0, 0, 2'b11, 2'b00, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        cycle(0, 0, 0, 2'b11, 2'b01, 32'h1, 32'h1);
        async_reset("rst_mid");

        // Randomized traffic against the model, with one extra reset midway
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset("rst_rand");
            rmode = 2'($urandom_range(0, 3));
            rwe   = 2'($urandom_range(0, 3));
            rhi   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rlo   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, rwe, rmode, rhi, rlo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
